ib_mul_feeder: RTL and testbench

//   Upstream issue/collect stage for the 4-cycle serial 8x8 multiplier ib_mul_8x8_s1_l4.
//   - Accepts operand pairs over a valid/ready stream and queues them in an operand FIFO.
//   - Drives the multiplier's start/operand pins, holding the operands stable while the multiply is in flight.
//   - Captures each 16-bit product into a 2-entry result queue and presents it over a valid/ready stream.

---
 rtl/ib_mul_pkg.sv | 25 ++
 rtl/ib_mul_8x8_s1_l4.sv | 65 ++++++
 rtl/ib_sync_fifo.sv | 62 ++++++
 rtl/ib_mul_feeder.sv | 146 ++++++++++++++
 tb/tb_ib_mul_feeder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/ib_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ib_mul_pkg
// Brief    : Shared widths, latencies and FSM encodings for the multiplier feeder.
// Revision : 1.0 - initial release
// ============================================================================
package ib_mul_pkg;

  localparam int MUL_W     = 8;
  localparam int PROD_W    = 16;
  localparam int MUL_LAT   = 4;
  localparam int RES_DEPTH = 2;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Two's complement magnitude; -128 maps onto 8'h80, which the unsigned core handles.
  function automatic logic [MUL_W-1:0] mag8(input logic [MUL_W-1:0] v);
    return v[MUL_W-1] ? (~v + 1'b1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ib_mul_8x8_s1_l4.sv
`default_nettype none
// ============================================================================
// Module   : ib_mul_8x8_s1_l4
// Brief    : Serial 8x8 unsigned multiplier, radix-4, done pulse 4 cycles after start.
// Revision : 1.0 - initial release
// ============================================================================
module ib_mul_8x8_s1_l4 (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic        i_start,
  input  logic [7:0]  i_a,
  input  logic [7:0]  i_b,
  output logic [15:0] o_c,
  output logic        o_done
);

  logic [15:0] r_acc;
  logic [15:0] r_a;
  logic [7:0]  r_b;
  logic [1:0]  r_cnt;
  logic        r_busy;
  logic        r_done;

  function automatic logic [15:0] pp(input logic [15:0] a, input logic [1:0] d);
    logic [15:0] s;
    s = d[0] ? a : 16'd0;
    if (d[1]) s = s + {a[14:0], 1'b0};
    return s;
  endfunction

  assign o_c    = r_acc;
  assign o_done = r_done;

  // The first digit is folded into the start edge so the last lands 3 edges later.
  always_ff @(posedge i_clk) begin
    if (!i_nrst) begin
      r_acc  <= '0;
      r_a    <= '0;
      r_b    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_acc  <= pp({8'd0, i_a}, i_b[1:0]);
        r_a    <= {6'd0, i_a, 2'b00};
        r_b    <= {2'b00, i_b[7:2]};
        r_cnt  <= 2'd1;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_acc <= r_acc + pp(r_a, r_b[1:0]);
        r_a   <= {r_a[13:0], 2'b00};
        r_b   <= {2'b00, r_b[7:2]};
        r_cnt <= r_cnt + 2'd1;
        if (r_cnt == 2'd3) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ib_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ib_sync_fifo
// Brief    : Single-clock FIFO with show-ahead read data and synchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module ib_sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full    = (r_count == C_FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_rd_data = r_mem[r_rptr];

  // A write into a full FIFO is accepted only when the same cycle frees a slot.
  assign w_rd = i_rd_en && !o_empty;
  assign w_wr = i_wr_en && (!o_full || w_rd);

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ib_mul_feeder.sv
`default_nettype none
// ============================================================================
// Module   : ib_mul_feeder
// Brief    : Operand FIFO -> serial multiplier issue -> 2-entry result queue.
//            Define IB_MUL_FEED_SIGNED_EN for two's complement operands/results.
// Revision : 1.0 - initial release
// ============================================================================
module ib_mul_feeder
  import ib_mul_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [MUL_W-1:0]  i_a,
  input  logic [MUL_W-1:0]  i_b,
  output logic              o_mul_start,
  output logic [MUL_W-1:0]  o_mul_a,
  output logic [MUL_W-1:0]  o_mul_b,
  input  logic [PROD_W-1:0] i_mul_c,
  input  logic              i_mul_done,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [PROD_W-1:0] o_c
);

  logic [2*MUL_W-1:0] w_op_head;
  logic               w_op_full;
  logic               w_op_empty;
  logic               w_res_full;
  logic               w_res_empty;
  logic [PROD_W-1:0]  w_cap_data;
  logic [MUL_W-1:0]   w_head_a;
  logic [MUL_W-1:0]   w_head_b;
  logic [MUL_W-1:0]   r_mul_a;
  logic [MUL_W-1:0]   r_mul_b;
  logic [1:0]         r_occ;
  logic               w_credit_ok;
  logic               w_start;
  logic               w_cap;
  logic               w_pop;
  state_t             r_state;
  state_t             w_state_nxt;

  ib_sync_fifo #(
    .WIDTH (2*MUL_W),
    .DEPTH (DEPTH)
  ) u_op_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (i_valid && o_ready),
    .i_wr_data ({i_a, i_b}),
    .i_rd_en   (w_start),
    .o_rd_data (w_op_head),
    .o_full    (w_op_full),
    .o_empty   (w_op_empty)
  );

  ib_sync_fifo #(
    .WIDTH (PROD_W),
    .DEPTH (RES_DEPTH)
  ) u_res_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_wr_en   (w_cap),
    .i_wr_data (w_cap_data),
    .i_rd_en   (w_pop),
    .o_rd_data (o_c),
    .o_full    (w_res_full),
    .o_empty   (w_res_empty)
  );

  assign o_ready = !w_op_full;
  assign o_valid = !w_res_empty;
  assign w_pop   = o_valid && i_ready;

`ifdef IB_MUL_FEED_SIGNED_EN
  logic r_sign;

  assign w_head_a   = mag8(w_op_head[2*MUL_W-1:MUL_W]);
  assign w_head_b   = mag8(w_op_head[MUL_W-1:0]);
  assign w_cap_data = r_sign ? (~i_mul_c + 1'b1) : i_mul_c;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sign <= 1'b0;
    end else if (w_start) begin
      r_sign <= w_op_head[2*MUL_W-1] ^ w_op_head[MUL_W-1];
    end
  end
`else
  assign w_head_a   = w_op_head[2*MUL_W-1:MUL_W];
  assign w_head_b   = w_op_head[MUL_W-1:0];
  assign w_cap_data = i_mul_c;
`endif

  // A pop in the same cycle returns a credit in time for the new start.
  assign w_credit_ok = (r_occ != 2'd2) || w_pop;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_start = !w_op_empty && w_credit_ok;
        if (w_start) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (i_mul_done) begin
          w_cap       = !w_res_full;
          w_start     = !w_op_empty && w_credit_ok;
          w_state_nxt = w_start ? ST_BUSY : ST_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_occ   <= 2'd0;
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else begin
      r_state <= w_state_nxt;
      case ({w_start, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
      if (w_start) begin
        r_mul_a <= w_head_a;
        r_mul_b <= w_head_b;
      end
    end
  end

  assign o_mul_start = w_start;
  assign o_mul_a     = w_start ? w_head_a : r_mul_a;
  assign o_mul_b     = w_start ? w_head_b : r_mul_b;

endmodule
`default_nettype wire

// File: tb/tb_ib_mul_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ib_mul_feeder
// Brief    : Scoreboard bench for ib_mul_feeder driving ib_mul_8x8_s1_l4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ib_mul_feeder;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        i_ready = 1'b0;
  logic [7:0]  i_a = '0;
  logic [7:0]  i_b = '0;
  logic        o_ready;
  logic        o_mul_start;
  logic [7:0]  o_mul_a;
  logic [7:0]  o_mul_b;
  logic [15:0] w_mul_c;
  logic        w_mul_done;
  logic        o_valid;
  logic [15:0] o_c;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  logic [15:0] exp_q[$];
  int          start_cyc[$];

  ib_mul_feeder #(.DEPTH(4)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_a         (i_a),
    .i_b         (i_b),
    .o_mul_start (o_mul_start),
    .o_mul_a     (o_mul_a),
    .o_mul_b     (o_mul_b),
    .i_mul_c     (w_mul_c),
    .i_mul_done  (w_mul_done),
    .o_valid     (o_valid),
    .i_ready     (i_ready),
    .o_c         (o_c)
  );

  ib_mul_8x8_s1_l4 u_mul (
    .i_clk   (i_clk),
    .i_nrst  (~i_rst),
    .i_start (o_mul_start),
    .i_a     (o_mul_a),
    .i_b     (o_mul_b),
    .o_c     (w_mul_c),
    .o_done  (w_mul_done)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each accepted result and logs start cycles.
  always @(negedge i_clk) begin
    if (!i_rst && o_valid && i_ready) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h with nothing expected", o_c);
      end else begin
        check("result", {16'd0, o_c}, {16'd0, exp_q.pop_front()});
      end
    end
    if (!i_rst && o_mul_start) start_cyc.push_back(cyc);
  end

  // Called at a negedge; returns at the negedge following the accepting edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [15:0] e);
    int g = 0;
    i_valid = 1'b1;
    i_a = a;
    i_b = b;
    while (!o_ready && g < 200) begin
      @(negedge i_clk);
      g++;
    end
    if (g >= 200) begin
      check("send_timeout", 32'd0, 32'd1);
    end else begin
      exp_q.push_back(e);
    end
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      @(negedge i_clk);
      g++;
    end
    @(negedge i_clk);
    check(nm, exp_q.size(), 32'd0);
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic [15:0] p; } vec_t;

`ifdef IB_MUL_FEED_SIGNED_EN
  vec_t stream_v[8] = '{
    '{8'hFD, 8'h05, 16'hFFF1}, '{8'h80, 8'h80, 16'h4000},
    '{8'h7F, 8'hFF, 16'hFF81}, '{8'hFF, 8'hFF, 16'h0001},
    '{8'h00, 8'h5A, 16'h0000}, '{8'h10, 8'h10, 16'h0100},
    '{8'h7F, 8'h02, 16'h00FE}, '{8'hF0, 8'hF0, 16'h0100}};
`else
  vec_t stream_v[8] = '{
    '{8'hFF, 8'hFF, 16'hFE01}, '{8'h00, 8'h5A, 16'h0000},
    '{8'h01, 8'h80, 16'h0080}, '{8'h10, 8'h10, 16'h0100},
    '{8'h7F, 8'h02, 16'h00FE}, '{8'hC8, 8'h03, 16'h0258},
    '{8'hAA, 8'h55, 16'h3872}, '{8'h12, 8'h34, 16'h03A8}};
`endif

  vec_t bp_v[6] = '{
    '{8'h02, 8'h03, 16'h0006}, '{8'h04, 8'h05, 16'h0014},
    '{8'h06, 8'h07, 16'h002A}, '{8'h08, 8'h09, 16'h0048},
    '{8'h0A, 8'h0B, 16'h006E}, '{8'h0C, 8'h0D, 16'h009C}};

  initial begin
    int seen;

    // Reset state
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("rst_o_ready", o_ready, 1);
    check("rst_o_valid", o_valid, 0);
    check("rst_o_mul_start", o_mul_start, 0);
    check("rst_o_mul_ab", {o_mul_a, o_mul_b}, 0);
    check("rst_o_c", o_c, 0);
    i_ready = 1'b1;

    // Single op latency: accept at T, start at T+1, result at T+6 only
    send(8'd13, 8'd11, 16'd143);
    check("single_start", o_mul_start, 1);
    check("single_ab_at_start", {o_mul_a, o_mul_b}, {8'd13, 8'd11});
    for (int k = 2; k <= 7; k++) begin
      @(negedge i_clk);
      check($sformatf("single_valid_T+%0d", k), o_valid, (k == 6) ? 1 : 0);
      if (k == 2) check("single_ab_held", {o_mul_a, o_mul_b}, {8'd13, 8'd11});
    end
    wait_drain("single_drain");

    // Streaming: back-to-back starts every 4 cycles
    start_cyc.delete();
    for (int i = 0; i < 8; i++) send(stream_v[i].a, stream_v[i].b, stream_v[i].p);
    wait_drain("stream_drain");
    check("stream_start_count", start_cyc.size(), 8);
    for (int i = 1; i < start_cyc.size(); i++)
      check($sformatf("stream_start_gap_%0d", i), start_cyc[i] - start_cyc[i-1], 4);

    // Backpressure: credits cap in-flight+held at 2, FIFO fills to DEPTH
    i_ready = 1'b0;
    start_cyc.delete();
    for (int i = 0; i < 6; i++) send(bp_v[i].a, bp_v[i].b, bp_v[i].p);
    check("bp_o_ready_low", o_ready, 0);
    repeat (12) @(negedge i_clk);
    check("bp_start_count", start_cyc.size(), 2);
    check("bp_o_valid", o_valid, 1);
    check("bp_o_c_held", o_c, 16'h0006);
    repeat (4) @(negedge i_clk);
    check("bp_o_c_stable", o_c, 16'h0006);
    check("bp_no_more_starts", start_cyc.size(), 2);
    check("bp_still_full", o_ready, 0);
    i_ready = 1'b1;
    wait_drain("bp_drain");
    check("bp_total_starts", start_cyc.size(), 6);

    // Reset two cycles after a start; the in-flight op is abandoned
    send(8'h21, 8'h03, 16'h0063);
    check("rstmid_start", o_mul_start, 1);
    repeat (2) @(negedge i_clk);
    i_rst = 1'b1;
    exp_q.delete();
    @(negedge i_clk);
    i_rst = 1'b0;
    check("rstmid_o_valid", o_valid, 0);
    check("rstmid_o_ready", o_ready, 1);
    seen = 0;
    repeat (10) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    check("rstmid_no_result", seen, 0);

    // Recovery after reset
    send(8'h07, 8'h06, 16'h002A);
    wait_drain("recover_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
